// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch-side and execute-side handshake bundle for the decode stage
interface decode_stage_if #(
  parameter int REG_ADDR_W = 4,
  parameter int PC_W       = 32
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [31:0]           in_instr;
  logic [PC_W-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_W-1:0]       out_pc;
  logic [REG_ADDR_W-1:0] out_rd;
  logic [REG_ADDR_W-1:0] out_rs1;
  logic [REG_ADDR_W-1:0] out_rs2;
  logic [2:0]            out_cls;
  logic [2:0]            out_alu_op;
  logic [2:0]            out_funct3;
  logic                  out_subtract;
  logic                  out_shift_right;
  logic                  out_shift_arith;
  logic                  out_is_imm;
  logic [31:0]           out_imm;
  logic                  out_illegal;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_cls, out_alu_op,
           out_funct3, out_subtract, out_shift_right, out_shift_arith, out_is_imm,
           out_imm, out_illegal
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_cls, out_alu_op,
           out_funct3, out_subtract, out_shift_right, out_shift_arith, out_is_imm,
           out_imm, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV32E decoder behind a 2-entry skid buffer
module decode_stage #(
  parameter int REG_ADDR_W = 4,
  parameter int PC_W       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  decode_stage_if.slave bus
);
  typedef struct packed {
    logic [PC_W-1:0]       pc;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [2:0]            cls;
    logic [2:0]            alu_op;
    logic [2:0]            funct3;
    logic                  subtract;
    logic                  shift_right;
    logic                  shift_arith;
    logic                  is_imm;
    logic [31:0]           imm;
    logic                  illegal;
  } ent_t;

  logic [31:0] ins;
  logic [4:0]  op;
  logic [2:0]  f3, alu_f;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic        bad, u_rd, u_rs1, u_rs2, acc;
  ent_t        ent_d, m_q, s_q;
  logic        m_v_q, s_v_q;

  assign ins   = bus.in_instr;
  assign op    = ins[6:2];
  assign f3    = ins[14:12];
  assign f7    = ins[31:25];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign alu_f = f3 == 3'd0 ? 3'd0 : f3[2:1] == 2'b01 ? 3'd1 : f3 == 3'd4 ? 3'd2 :
                 f3 == 3'd6 ? 3'd3 : f3 == 3'd7 ? 3'd4 : 3'd5;
  assign acc   = bus.in_valid & ~s_v_q & ~bus.flush;

  // Decode the presented instruction; only register fields the format actually reads count for RV32E range checks
  always_comb begin
    ent_d             = '0;
    bad               = 1'b0;
    u_rd              = 1'b0;
    u_rs1             = 1'b0;
    u_rs2             = 1'b0;
    ent_d.pc          = bus.in_pc;
    ent_d.rd          = ins[7+:REG_ADDR_W];
    ent_d.rs1         = ins[15+:REG_ADDR_W];
    ent_d.rs2         = ins[20+:REG_ADDR_W];
    ent_d.funct3      = f3;
    ent_d.shift_right = f3[2];
    ent_d.shift_arith = ins[30];
    case (op)
      5'b01100: begin
        ent_d.alu_op   = alu_f;
        ent_d.subtract = (f3 == 3'd0 & ins[30]) | f3[2:1] == 2'b01;
        bad            = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
        {u_rd, u_rs1, u_rs2} = 3'b111;
      end
      5'b00100: begin
        ent_d.alu_op   = alu_f;
        ent_d.subtract = f3[2:1] == 2'b01;
        ent_d.is_imm   = 1'b1;
        ent_d.imm      = imm_i;
        bad            = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
        {u_rd, u_rs1}  = 2'b11;
      end
      5'b00000: begin
        ent_d.cls      = 3'd1;
        ent_d.is_imm   = 1'b1;
        ent_d.imm      = imm_i;
        bad            = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
        {u_rd, u_rs1}  = 2'b11;
      end
      5'b01000: begin
        ent_d.cls      = 3'd2;
        ent_d.is_imm   = 1'b1;
        ent_d.imm      = imm_s;
        bad            = f3 >= 3'd3;
        {u_rs1, u_rs2} = 2'b11;
      end
      5'b11000: begin
        ent_d.cls      = 3'd3;
        ent_d.alu_op   = 3'd1;
        ent_d.subtract = 1'b1;
        ent_d.imm      = imm_b;
        bad            = f3[2:1] == 2'b01;
        {u_rs1, u_rs2} = 2'b11;
      end
      5'b11011: begin
        ent_d.cls      = 3'd4;
        ent_d.is_imm   = 1'b1;
        ent_d.imm      = imm_j;
        u_rd           = 1'b1;
      end
      5'b11001: begin
        ent_d.cls      = 3'd5;
        ent_d.is_imm   = 1'b1;
        ent_d.imm      = imm_i;
        bad            = f3 != 3'd0;
        {u_rd, u_rs1}  = 2'b11;
      end
      5'b01101, 5'b00101: begin
        ent_d.cls      = op[3] ? 3'd6 : 3'd7;
        ent_d.is_imm   = 1'b1;
        ent_d.imm      = imm_u;
        u_rd           = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    ent_d.illegal = bad | ins[1:0] != 2'b11 |
                    (REG_ADDR_W == 4 && ((u_rd & ins[11]) | (u_rs1 & ins[19]) | (u_rs2 & ins[24])));
  end

  // Skid buffer: main slot feeds execute, skid slot absorbs one accept while execute stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
      m_q   <= '0;
      s_q   <= '0;
    end else if (bus.flush) begin
      m_v_q <= 1'b0;
      s_v_q <= 1'b0;
    end else if (s_v_q) begin
      if (bus.out_ready) begin
        m_q   <= s_q;
        s_v_q <= 1'b0;
      end
    end else if (m_v_q & ~bus.out_ready) begin
      if (acc) begin
        s_q   <= ent_d;
        s_v_q <= 1'b1;
      end
    end else begin
      m_v_q <= acc;
      if (acc) m_q <= ent_d;
    end
  end

  assign bus.in_ready        = ~s_v_q;
  assign bus.out_valid       = m_v_q;
  assign bus.out_pc          = m_q.pc;
  assign bus.out_rd          = m_q.rd;
  assign bus.out_rs1         = m_q.rs1;
  assign bus.out_rs2         = m_q.rs2;
  assign bus.out_cls         = m_q.cls;
  assign bus.out_alu_op      = m_q.alu_op;
  assign bus.out_funct3      = m_q.funct3;
  assign bus.out_subtract    = m_q.subtract;
  assign bus.out_shift_right = m_q.shift_right;
  assign bus.out_shift_arith = m_q.shift_arith;
  assign bus.out_is_imm      = m_q.is_imm;
  assign bus.out_imm         = m_q.imm;
  assign bus.out_illegal     = m_q.illegal;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: queue-model bench for decode_stage, RV32E and RV32I instances side by side
module tb_decode_stage;
  logic clk, rst_n;
  int   checks, errors;

  decode_stage_if #(.REG_ADDR_W(4)) if4 ();
  decode_stage_if #(.REG_ADDR_W(5)) if5 ();

  decode_stage #(.REG_ADDR_W(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  decode_stage #(.REG_ADDR_W(5)) u5 (.clk(clk), .rst_n(rst_n), .bus(if5));

  assign if5.flush     = if4.flush;
  assign if5.in_valid  = if4.in_valid;
  assign if5.in_instr  = if4.in_instr;
  assign if5.in_pc     = if4.in_pc;
  assign if5.out_ready = if4.out_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  typedef struct {
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  cls, alu, f3;
    logic        sub, sr, sa, isimm, ill;
    logic [31:0] imm;
  } exp_t;

  item_t       q[$];
  logic [31:0] log_pc[$];

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endfunction

  function automatic logic [2:0] alu_of(logic [2:0] f);
    case (f)
      3'd0:       return 3'd0;
      3'd2, 3'd3: return 3'd1;
      3'd4:       return 3'd2;
      3'd6:       return 3'd3;
      3'd7:       return 3'd4;
      default:    return 3'd5;
    endcase
  endfunction

  function automatic exp_t dec(logic [31:0] i, int w);
    exp_t       e;
    logic [6:0] f7;
    logic [2:0] f3;
    bit         rd_u, rs1_u, rs2_u, bad;
    f7 = i[31:25];
    f3 = i[14:12];
    e = '{rd: i[11:7], rs1: i[19:15], rs2: i[24:20], cls: 0, alu: 0, f3: f3,
          sub: 0, sr: f3[2], sa: i[30], isimm: 0, ill: 0, imm: 0};
    rd_u = 0; rs1_u = 0; rs2_u = 0; bad = 0;
    case (i[6:2])
      5'b01100: begin
        e.alu = alu_of(f3); e.sub = (f3 == 0 && i[30]) || f3 == 2 || f3 == 3;
        bad = !(f7 == 0 || (f7 == 7'b0100000 && (f3 == 0 || f3 == 5)));
        rd_u = 1; rs1_u = 1; rs2_u = 1;
      end
      5'b00100: begin
        e.alu = alu_of(f3); e.sub = f3 == 2 || f3 == 3; e.isimm = 1;
        e.imm = {{20{i[31]}}, i[31:20]};
        if (f3 == 1) bad = f7 != 0;
        if (f3 == 5) bad = f7 != 0 && f7 != 7'b0100000;
        rd_u = 1; rs1_u = 1;
      end
      5'b00000: begin
        e.cls = 1; e.isimm = 1; e.imm = {{20{i[31]}}, i[31:20]};
        bad = f3 == 3 || f3 == 6 || f3 == 7; rd_u = 1; rs1_u = 1;
      end
      5'b01000: begin
        e.cls = 2; e.isimm = 1; e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        bad = f3 >= 3; rs1_u = 1; rs2_u = 1;
      end
      5'b11000: begin
        e.cls = 3; e.alu = 1; e.sub = 1;
        e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        bad = f3 == 2 || f3 == 3; rs1_u = 1; rs2_u = 1;
      end
      5'b11011: begin
        e.cls = 4; e.isimm = 1; e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        rd_u = 1;
      end
      5'b11001: begin
        e.cls = 5; e.isimm = 1; e.imm = {{20{i[31]}}, i[31:20]}; bad = f3 != 0;
        rd_u = 1; rs1_u = 1;
      end
      5'b01101: begin e.cls = 6; e.isimm = 1; e.imm = {i[31:12], 12'b0}; rd_u = 1; end
      5'b00101: begin e.cls = 7; e.isimm = 1; e.imm = {i[31:12], 12'b0}; rd_u = 1; end
      default:  bad = 1;
    endcase
    if (i[1:0] != 2'b11) bad = 1;
    if (w == 4 && ((rd_u && i[11]) || (rs1_u && i[19]) || (rs2_u && i[24]))) bad = 1;
    e.ill = bad;
    if (w == 4) begin e.rd[4] = 0; e.rs1[4] = 0; e.rs2[4] = 0; end
    return e;
  endfunction

  function automatic void cmp(string t, exp_t e, logic [31:0] epc, logic [31:0] pc,
                              logic [31:0] rd, logic [31:0] rs1, logic [31:0] rs2,
                              logic [2:0] cls, logic [2:0] alu, logic [2:0] f3,
                              logic sub, logic sr, logic sa, logic isimm,
                              logic [31:0] imm, logic ill);
    chk({t, " pc"}, pc, epc);
    chk({t, " rd"}, rd, 32'(e.rd));
    chk({t, " rs1"}, rs1, 32'(e.rs1));
    chk({t, " rs2"}, rs2, 32'(e.rs2));
    chk({t, " cls"}, 32'(cls), 32'(e.cls));
    chk({t, " alu_op"}, 32'(alu), 32'(e.alu));
    chk({t, " funct3"}, 32'(f3), 32'(e.f3));
    chk({t, " flags"}, {28'd0, sub, sr, sa, isimm}, {28'd0, e.sub, e.sr, e.sa, e.isimm});
    chk({t, " imm"}, imm, e.imm);
    chk({t, " illegal"}, 32'(ill), 32'(e.ill));
  endfunction

  // Reference model: an ordered queue of at most two entries, cleared by reset or flush
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q.delete();
    else if (if4.flush) q.delete();
    else begin
      automatic bit pop = q.size() > 0 && if4.out_ready;
      automatic bit acc = if4.in_valid && q.size() < 2;
      if (pop) void'(q.pop_front());
      if (acc) q.push_back('{if4.in_instr, if4.in_pc});
    end
  end

  // Per-cycle comparison against the model, away from the rising edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("w4 in_ready", 32'(if4.in_ready), 32'(q.size() < 2));
      chk("w5 in_ready", 32'(if5.in_ready), 32'(q.size() < 2));
      chk("w4 out_valid", 32'(if4.out_valid), 32'(q.size() > 0));
      chk("w5 out_valid", 32'(if5.out_valid), 32'(q.size() > 0));
      if (q.size() > 0) begin
        cmp("w4", dec(q[0].instr, 4), q[0].pc, if4.out_pc, 32'(if4.out_rd), 32'(if4.out_rs1),
            32'(if4.out_rs2), if4.out_cls, if4.out_alu_op, if4.out_funct3, if4.out_subtract,
            if4.out_shift_right, if4.out_shift_arith, if4.out_is_imm, if4.out_imm, if4.out_illegal);
        cmp("w5", dec(q[0].instr, 5), q[0].pc, if5.out_pc, 32'(if5.out_rd), 32'(if5.out_rs1),
            32'(if5.out_rs2), if5.out_cls, if5.out_alu_op, if5.out_funct3, if5.out_subtract,
            if5.out_shift_right, if5.out_shift_arith, if5.out_is_imm, if5.out_imm, if5.out_illegal);
      end
      if (if4.out_valid && if4.out_ready) log_pc.push_back(if4.out_pc);
    end
  end

  localparam logic [31:0] TV [14] = '{
    32'h00C58863, 32'h008000EF, 32'h000100E7, 32'h123450B7, 32'h00001097, 32'h00112223,
    32'h40115093, 32'h00013083, 32'h0020C0B3, 32'h0000A0B3, 32'h00000012, 32'h02000033,
    32'h40001093, 32'hFE000EE3
  };

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic v, logic [31:0] instr, logic [31:0] pc);
    if4.in_valid = v;
    if4.in_instr = instr;
    if4.in_pc    = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int  k;
    bit  a;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    if4.flush = 1'b0;
    if4.out_ready = 1'b0;
    put(0, 0, 0);
    #12;
    chk("reset out_valid", 32'(if4.out_valid), 0);
    chk("reset in_ready", 32'(if4.in_ready), 1);
    chk("reset out_pc", if4.out_pc, 0);
    chk("reset out_imm", if4.out_imm, 0);
    chk("reset out_cls", 32'(if4.out_cls), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    if4.out_ready = 1'b1;
    put(1, 32'h00510093, 32'h100);
    cyc();
    chk("addi out_valid", 32'(if4.out_valid), 1);
    chk("addi rd", 32'(if4.out_rd), 1);
    chk("addi rs1", 32'(if4.out_rs1), 2);
    chk("addi cls/alu", {if4.out_cls, if4.out_alu_op}, 0);
    chk("addi is_imm", 32'(if4.out_is_imm), 1);
    chk("addi imm", if4.out_imm, 32'h5);
    chk("addi illegal", 32'(if4.out_illegal), 0);
    put(1, 32'h402081B3, 32'h104);
    cyc();
    chk("sub subtract", 32'(if4.out_subtract), 1);
    chk("sub is_imm", 32'(if4.out_is_imm), 0);
    chk("sub imm", if4.out_imm, 0);
    chk("sub rd", 32'(if4.out_rd), 3);
    put(1, 32'hFFC12283, 32'h108);
    cyc();
    chk("lw cls", 32'(if4.out_cls), 1);
    chk("lw funct3", 32'(if4.out_funct3), 2);
    chk("lw imm", if4.out_imm, 32'hFFFFFFFC);
    chk("lw rd", 32'(if4.out_rd), 5);
    put(1, 32'h00000833, 32'h10C);
    cyc();
    chk("x16 illegal rv32e", 32'(if4.out_illegal), 1);
    chk("x16 illegal rv32i", 32'(if5.out_illegal), 0);
    chk("x16 rd rv32i", 32'(if5.out_rd), 16);
    put(1, 32'h0000000F, 32'h110);
    cyc();
    chk("fence illegal rv32e", 32'(if4.out_illegal), 1);
    chk("fence illegal rv32i", 32'(if5.out_illegal), 1);
    put(0, 0, 0);
    repeat (2) cyc();

    foreach (TV[i]) begin
      put(1, TV[i], 32'h200 + 32'(i) * 4);
      a = 0;
      for (int c = 0; c < 10 && !a; c++) begin
        if4.out_ready = ((i + c) % 3) != 0;
        a = if4.in_ready;
        cyc();
      end
      chk("table accept", 32'(a), 1);
    end
    put(0, 0, 0);
    if4.out_ready = 1'b1;
    repeat (3) cyc();

    log_pc.delete();
    k = 0;
    for (int c = 0; c < 20 && k < 4; c++) begin
      if4.out_ready = c >= 3;
      put(1, 32'h00000013, 32'(k) * 4);
      if (c == 2) chk("stream in_ready after 2 accepts", 32'(if4.in_ready), 0);
      a = if4.in_ready;
      cyc();
      if (a) k++;
    end
    chk("stream accepted", 32'(k), 4);
    put(0, 0, 0);
    if4.out_ready = 1'b1;
    repeat (4) cyc();
    chk("stream delivered", 32'(log_pc.size()), 4);
    for (int i = 0; i < 4; i++)
      chk("stream order", log_pc.size() > i ? log_pc[i] : 32'hDEAD, 32'(i) * 4);

    log_pc.delete();
    if4.out_ready = 1'b0;
    put(1, 32'h00000013, 32'h20);
    cyc();
    put(1, 32'h00000013, 32'h24);
    cyc();
    chk("pre-flush full", 32'(if4.in_ready), 0);
    put(1, 32'h00000013, 32'h28);
    if4.flush = 1'b1;
    cyc();
    if4.flush = 1'b0;
    put(0, 0, 0);
    chk("flush out_valid", 32'(if4.out_valid), 0);
    chk("flush in_ready", 32'(if4.in_ready), 1);
    if4.out_ready = 1'b1;
    repeat (3) cyc();
    chk("flushed never delivered", 32'(log_pc.size()), 0);

    if4.out_ready = 1'b0;
    put(1, 32'h00510093, 32'h40);
    cyc();
    put(1, 32'h00510093, 32'h44);
    cyc();
    put(0, 0, 0);
    chk("pre-reset full", 32'(if4.in_ready), 0);
    #3 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", 32'(if4.out_valid), 0);
    chk("async reset in_ready", 32'(if4.in_ready), 1);
    chk("async reset out_pc", if4.out_pc, 0);
    chk("async reset out_imm", if4.out_imm, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    if4.out_ready = 1'b1;
    put(1, 32'h00510093, 32'h50);
    cyc();
    chk("post-reset out_valid", 32'(if4.out_valid), 1);
    chk("post-reset out_pc", if4.out_pc, 32'h50);
    put(0, 0, 0);
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
